// File: rtl/cbus_arbiter.sv
// Round-robin arbiter merging NUM_MASTERS CBus requesters onto one CBus port.
// The grant is held for a whole transaction and responses are routed only to the granted master.
module cbus_arbiter_lane (
  input  logic        sel,
  input  logic [63:0] rdata,
  input  logic        ready,
  input  logic        last,
  output logic [63:0] m_rdata,
  output logic        m_ready,
  output logic        m_last
);
  assign m_rdata = sel ? rdata : '0;
  assign m_ready = sel & ready;
  assign m_last  = sel & last;
endmodule

module cbus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_MASTERS-1:0]    m_valid,
  input  logic [NUM_MASTERS*64-1:0] m_addr,
  input  logic [NUM_MASTERS*64-1:0] m_wdata,
  input  logic [NUM_MASTERS*2-1:0]  m_burst,
  input  logic [NUM_MASTERS*8-1:0]  m_len,
  input  logic [NUM_MASTERS*8-1:0]  m_wstrobe,
  output logic [NUM_MASTERS*64-1:0] m_rdata,
  output logic [NUM_MASTERS-1:0]    m_ready,
  output logic [NUM_MASTERS-1:0]    m_last,
  output logic                     valid,
  output logic [63:0]              addr,
  output logic [63:0]              wdata,
  output logic [1:0]               burst,
  output logic [7:0]               len,
  output logic [7:0]               wstrobe,
  input  logic [63:0]              rdata,
  input  logic                     ready,
  input  logic                     last
);
  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  burst;
    logic [7:0]  len;
    logic [7:0]  wstrobe;
  } req_t;

  state_t                  fsm_q, fsm_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic                    found;
  int                      idx;
  req_t [NUM_MASTERS-1:0]  m_req;
  req_t                    req;
  logic [NUM_MASTERS-1:0]  lane_sel;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_lane
    assign m_req[i].addr    = m_addr[64*i +: 64];
    assign m_req[i].wdata   = m_wdata[64*i +: 64];
    assign m_req[i].burst   = m_burst[2*i +: 2];
    assign m_req[i].len     = m_len[8*i +: 8];
    assign m_req[i].wstrobe = m_wstrobe[8*i +: 8];
    assign lane_sel[i]      = (fsm_q == BUSY) && (grant_q == IDX_W'(i));

    cbus_arbiter_lane u_lane (
      .sel     (lane_sel[i]),
      .rdata   (rdata),
      .ready   (ready),
      .last    (last),
      .m_rdata (m_rdata[64*i +: 64]),
      .m_ready (m_ready[i]),
      .m_last  (m_last[i])
    );
  end

  // Outputs decode straight from fsm_q, so an async reset clears them without a clock edge.
  always_comb begin
    valid = 1'b0;
    req   = '0;
    if (fsm_q == BUSY) begin
      valid = m_valid[grant_q];
      req   = m_req[grant_q];
    end
  end

  assign addr    = req.addr;
  assign wdata   = req.wdata;
  assign burst   = req.burst;
  assign len     = req.len;
  assign wstrobe = req.wstrobe;

  always_comb begin
    fsm_d    = fsm_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    found    = 1'b0;
    idx      = 0;
    case (fsm_q)
      IDLE: begin
        // First requester at or after rr_ptr wins, wrapping around.
        for (int i = 0; i < NUM_MASTERS; i++) begin
          idx = (int'(rr_ptr_q) + i) % NUM_MASTERS;
          if (!found && m_valid[idx]) begin
            found   = 1'b1;
            grant_d = IDX_W'(idx);
            fsm_d   = BUSY;
          end
        end
      end
      BUSY: begin
        if (valid && ready && last) begin
          fsm_d    = IDLE;
          rr_ptr_d = IDX_W'((int'(grant_q) + 1) % NUM_MASTERS);
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q    <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      fsm_q    <= fsm_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter with two masters: arbitration order, burst hold,
// response isolation, async reset and last-without-ready handling.
module tb_cbus_arbiter;
  localparam int N = 2;

  logic            clk, reset;
  logic [N-1:0]    m_valid;
  logic [N*64-1:0] m_addr, m_wdata, m_rdata;
  logic [N*2-1:0]  m_burst;
  logic [N*8-1:0]  m_len, m_wstrobe;
  logic [N-1:0]    m_ready, m_last;
  logic            valid, ready, last;
  logic [63:0]     addr, wdata, rdata;
  logic [1:0]      burst;
  logic [7:0]      len, wstrobe;

  int checks = 0;
  int errors = 0;

  cbus_arbiter #(.NUM_MASTERS(N)) dut (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_burst(m_burst),
    .m_len(m_len), .m_wstrobe(m_wstrobe), .m_rdata(m_rdata), .m_ready(m_ready),
    .m_last(m_last), .valid(valid), .addr(addr), .wdata(wdata), .burst(burst),
    .len(len), .wstrobe(wstrobe), .rdata(rdata), .ready(ready), .last(last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic [63:0] a, input logic [7:0] l,
                         input logic [7:0] ws, input logic [63:0] wd);
    m_valid[m]          = 1'b1;
    m_addr[64*m +: 64]  = a;
    m_wdata[64*m +: 64] = wd;
    m_burst[2*m +: 2]   = 2'b01;
    m_len[8*m +: 8]     = l;
    m_wstrobe[8*m +: 8] = ws;
  endtask

  task automatic clr_req(input int m);
    m_valid[m]          = 1'b0;
    m_addr[64*m +: 64]  = '0;
    m_wdata[64*m +: 64] = '0;
    m_burst[2*m +: 2]   = '0;
    m_len[8*m +: 8]     = '0;
    m_wstrobe[8*m +: 8] = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_req(0, 64'h1111, 8'd0, 8'h0, 64'h0);
    set_req(1, 64'h2222, 8'd0, 8'h0, 64'h0);
    ready = 1'b1; last = 1'b1; rdata = 64'hFFFF;
    tick(); tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
    checks++; if (addr !== 64'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", addr); end
    checks++; if (m_ready !== 2'b00 || m_last !== 2'b00) begin errors++; $display("FAIL reset_mresp got ready %b last %b exp 00", m_ready, m_last); end
    checks++; if (m_rdata !== '0) begin errors++; $display("FAIL reset_mrdata got %h exp 0", m_rdata); end
    checks++; if (dut.rr_ptr_q !== 1'b0) begin errors++; $display("FAIL reset_rrptr got %b exp 0", dut.rr_ptr_q); end
    clr_req(0); clr_req(1);
    ready = 1'b0; last = 1'b0; rdata = '0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    set_req(0, 64'h8000_0000, 8'd0, 8'h00, 64'h0);
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_same_cycle got %b exp 0", valid); end
    tick();
    checks++; if (valid !== 1'b1 || addr !== 64'h8000_0000) begin errors++; $display("FAIL single_fwd got v=%b a=%h exp v=1 a=80000000", valid, addr); end
    ready = 1'b1; last = 1'b1; rdata = 64'hDEAD;
    #1;
    checks++; if (m_ready !== 2'b01 || m_last !== 2'b01) begin errors++; $display("FAIL single_resp got ready %b last %b exp 01", m_ready, m_last); end
    checks++; if (m_rdata !== {64'h0, 64'hDEAD}) begin errors++; $display("FAIL single_rdata got %h exp DEAD in lane 0 only", m_rdata); end
    tick();
    clr_req(0); ready = 1'b0; last = 1'b0; rdata = '0;
    #1;
    checks++; if (valid !== 1'b0 || dut.rr_ptr_q !== 1'b1) begin errors++; $display("FAIL single_exit got v=%b rr=%b exp v=0 rr=1", valid, dut.rr_ptr_q); end
  endtask

  task automatic test_contention();
    reset = 1'b1; #1; reset = 1'b0;
    set_req(0, 64'hA000, 8'd0, 8'h00, 64'h0);
    set_req(1, 64'hA111, 8'd0, 8'h00, 64'h0);
    tick();
    checks++; if (addr !== 64'hA000) begin errors++; $display("FAIL cont_first got %h exp A000", addr); end
    ready = 1'b1; last = 1'b1;
    #1;
    checks++; if (m_ready !== 2'b01) begin errors++; $display("FAIL cont_first_resp got %b exp 01", m_ready); end
    tick();
    set_req(0, 64'hA222, 8'd0, 8'h00, 64'h0);
    ready = 1'b0; last = 1'b0;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL cont_idle_gap got %b exp 0", valid); end
    tick();
    checks++; if (valid !== 1'b1 || addr !== 64'hA111) begin errors++; $display("FAIL cont_second got v=%b a=%h exp v=1 a=A111", valid, addr); end
    ready = 1'b1; last = 1'b1;
    #1;
    checks++; if (m_ready !== 2'b10) begin errors++; $display("FAIL cont_second_resp got %b exp 10", m_ready); end
    tick();
    clr_req(1); ready = 1'b0; last = 1'b0;
    tick();
    checks++; if (valid !== 1'b1 || addr !== 64'hA222) begin errors++; $display("FAIL cont_third got v=%b a=%h exp v=1 a=A222", valid, addr); end
    ready = 1'b1; last = 1'b1;
    tick();
    clr_req(0); ready = 1'b0; last = 1'b0;
    tick();
  endtask

  task automatic test_burst();
    set_req(1, 64'hB000, 8'd3, 8'hFF, 64'hCAFE_F00D);
    tick();
    checks++; if (valid !== 1'b1 || len !== 8'd3 || wstrobe !== 8'hFF || wdata !== 64'hCAFE_F00D) begin
      errors++; $display("FAIL burst_fwd got v=%b len=%h ws=%h wd=%h exp 1/03/FF/CAFEF00D", valid, len, wstrobe, wdata); end
    set_req(0, 64'hC000, 8'd0, 8'h00, 64'h0);
    for (int b = 0; b < 4; b++) begin
      ready = 1'b0; last = 1'b0;
      #1;
      checks++; if (valid !== 1'b1 || addr !== 64'hB000 || m_ready !== 2'b00) begin
        errors++; $display("FAIL burst_gap%0d got v=%b a=%h mr=%b exp 1/B000/00", b, valid, addr, m_ready); end
      tick();
      ready = 1'b1; last = (b == 3); rdata = 64'h100 + 64'(b);
      #1;
      checks++; if (m_ready !== 2'b10 || m_rdata[127:64] !== 64'h100 + 64'(b) || m_rdata[63:0] !== 64'h0) begin
        errors++; $display("FAIL burst_beat%0d got mr=%b rd=%h exp 10 / %h", b, m_ready, m_rdata, 64'h100 + 64'(b)); end
      tick();
    end
    clr_req(1); ready = 1'b0; last = 1'b0; rdata = '0;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL burst_exit got %b exp 0", valid); end
    tick();
    checks++; if (addr !== 64'hC000) begin errors++; $display("FAIL burst_next got %h exp C000", addr); end
    ready = 1'b1; last = 1'b1;
    tick();
    clr_req(0); ready = 1'b0; last = 1'b0;
    tick();
  endtask

  task automatic test_isolation();
    set_req(0, 64'hD000, 8'd2, 8'h00, 64'h0);
    tick();
    set_req(1, 64'h1000_0000, 8'd3, 8'h00, 64'h0);
    for (int c = 0; c < 5; c++) begin
      ready = (c == 1 || c == 3 || c == 4); last = (c == 4); rdata = 64'h5A5A;
      #1;
      checks++; if (addr !== 64'hD000 || m_ready[1] !== 1'b0 || m_rdata[127:64] !== 64'h0) begin
        errors++; $display("FAIL iso_cyc%0d got a=%h mr1=%b rd1=%h exp D000/0/0", c, addr, m_ready[1], m_rdata[127:64]); end
      tick();
    end
    clr_req(0); ready = 1'b0; last = 1'b0; rdata = '0;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL iso_exit got %b exp 0", valid); end
    tick();
    checks++; if (valid !== 1'b1 || addr !== 64'h1000_0000) begin errors++; $display("FAIL iso_next got v=%b a=%h exp 1/10000000", valid, addr); end
  endtask

  task automatic test_async_reset();
    ready = 1'b1; last = 1'b0; rdata = 64'h77;
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (valid !== 1'b0 || addr !== 64'h0 || m_ready !== 2'b00) begin
      errors++; $display("FAIL areset_imm got v=%b a=%h mr=%b exp 0/0/00", valid, addr, m_ready); end
    set_req(0, 64'hE000, 8'd0, 8'h00, 64'h0);
    tick();
    checks++; if (dut.rr_ptr_q !== 1'b0) begin errors++; $display("FAIL areset_rrptr got %b exp 0", dut.rr_ptr_q); end
    #2;
    reset = 1'b0; ready = 1'b0; rdata = '0;
    tick();
    checks++; if (addr !== 64'hE000) begin errors++; $display("FAIL areset_arb got %h exp E000", addr); end
    ready = 1'b1; last = 1'b1;
    tick();
    clr_req(0); ready = 1'b0; last = 1'b0;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL areset_gap got %b exp 0", valid); end
    tick();
    checks++; if (valid !== 1'b1 || addr !== 64'h1000_0000) begin errors++; $display("FAIL areset_m1 got v=%b a=%h exp 1/10000000", valid, addr); end
  endtask

  task automatic test_last_no_ready();
    for (int k = 0; k < 3; k++) begin
      ready = 1'b0; last = 1'b1;
      #1;
      checks++; if (valid !== 1'b1 || m_ready !== 2'b00 || m_last !== 2'b10) begin
        errors++; $display("FAIL lnr_cyc%0d got v=%b mr=%b ml=%b exp 1/00/10", k, valid, m_ready, m_last); end
      tick();
    end
    ready = 1'b1;
    #1;
    checks++; if (m_ready !== 2'b10) begin errors++; $display("FAIL lnr_ready got %b exp 10", m_ready); end
    tick();
    clr_req(1); ready = 1'b0; last = 1'b0;
    #1;
    checks++; if (valid !== 1'b0 || dut.rr_ptr_q !== 1'b0) begin errors++; $display("FAIL lnr_exit got v=%b rr=%b exp 0/0", valid, dut.rr_ptr_q); end
  endtask

  initial begin
    m_valid = '0; m_addr = '0; m_wdata = '0; m_burst = '0; m_len = '0; m_wstrobe = '0;
    ready = 1'b0; last = 1'b0; rdata = '0; reset = 1'b1;
    test_reset();
    test_single_read();
    test_contention();
    test_burst();
    test_isolation();
    test_async_reset();
    test_last_no_ready();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cbus_arbiter.md
Name: cbus_arbiter

Overview:
- Upstream neighbour of the CBus address crossbar: merges NUM_MASTERS independent CBus requesters (e.g. icache, dcache) into the single CBus port the crossbar consumes.
- Round-robin arbitration with grant held for a whole transaction, including multi-beat bursts.
- Routes the response beats (rdata/ready/last) back only to the granted master.

Parameters:
- NUM_MASTERS, 2, number of requesting CBus masters; legal range 2..8.
- IDX_W, $clog2(NUM_MASTERS), width of the grant index; derived, never overridden.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- m_valid  input  NUM_MASTERS  per-master request valid.
- m_addr  input  NUM_MASTERS*64  per-master address, master i at bits [64*i +: 64].
- m_wdata  input  NUM_MASTERS*64  per-master write data.
- m_burst  input  NUM_MASTERS*2  per-master burst type.
- m_len  input  NUM_MASTERS*8  per-master beat count minus one.
- m_wstrobe  input  NUM_MASTERS*8  per-master byte write strobes; all zero means read.
- m_rdata  output  NUM_MASTERS*64  read data returned to each master.
- m_ready  output  NUM_MASTERS  per-master beat-accepted/valid strobe.
- m_last  output  NUM_MASTERS  per-master final-beat flag.
- valid  output  1  request valid to the crossbar.
- addr  output  64  forwarded address.
- wdata  output  64  forwarded write data.
- burst  output  2  forwarded burst type.
- len  output  8  forwarded length.
- wstrobe  output  8  forwarded strobes.
- rdata  input  64  read data from the crossbar.
- ready  input  1  beat handshake from the crossbar.
- last  input  1  final-beat flag from the crossbar.

Behaviour:
- Clock and reset are fixed: one clock `clk`; `reset` is asynchronous and active-high.
- CBus rules:
  - A master holds valid and all request fields stable until it sees ready && last.
  - A beat completes on any cycle with valid && ready.
  - A transaction completes on valid && ready && last.
- Registered state: fsm ∈ {IDLE, BUSY}, grant (IDX_W), rr_ptr (IDX_W).
- Reset values: fsm=IDLE, grant=0, rr_ptr=0.
  - All outputs reset to 0: valid=0; addr, wdata, burst, len, wstrobe = 0; m_ready=0, m_last=0, m_rdata=0.
- IDLE:
  - valid=0 and all downstream request fields are 0.
  - m_ready=0, m_last=0, m_rdata=0 for every master.
  - If any m_valid bit is set, grant ← the first requesting index found searching rr_ptr, rr_ptr+1, … modulo NUM_MASTERS; fsm ← BUSY.
  - Arbitration latency is exactly 1 cycle: the request appears downstream on the cycle after it is first seen in IDLE.
- BUSY:
  - Downstream valid/addr/wdata/burst/len/wstrobe are the granted master's inputs, combinationally.
  - m_ready[grant]=ready, m_last[grant]=last, m_rdata[grant]=rdata.
  - Every non-granted master sees ready=0, last=0, rdata=0.
  - Requests from other masters are ignored and they wait; no preemption.
- BUSY exit: on the cycle with valid && ready && last → fsm ← IDLE, rr_ptr ← (grant+1) mod NUM_MASTERS.
  - There is therefore at least one idle cycle between back-to-back transactions.
- ready without last: stay BUSY; the burst continues. last asserted without ready: ignored.
- Granted master drops m_valid mid-transaction: this is a protocol violation. The grant is held and downstream valid follows m_valid[grant] (goes low). The arbiter never aborts on its own.
- Simultaneous requests: resolved by rr_ptr only. No master wins twice in a row while another is requesting.
- Reset mid-transaction: immediate return to IDLE, all outputs forced 0, rr_ptr=0. Any in-flight downstream burst is abandoned; downstream is reset by the same signal.
- Zero arithmetic on data; fields are passed through bit-exact.

Test Plan:
- Single read: m_valid=01, m_addr[0]=0x8000_0000, len=0. Required: valid high on the next cycle with addr=0x8000_0000; ready=1, last=1, rdata=0xDEAD → m_ready[0]=1, m_rdata[0]=0xDEAD; fsm back to IDLE, rr_ptr=1.
- Contention: both masters request in the same cycle from reset. Required: master 0 granted first, master 1 granted after master 0 completes and one idle cycle; a third concurrent request from master 0 is granted only after master 1.
- Burst: master 1, len=3, wstrobe=0xFF, ready pulsed on 4 non-consecutive cycles with last on the 4th. Required: grant stays 1 throughout, m_ready[0] stays 0, and exit happens only after the 4th beat.
- Isolation: master 0 is in a BUSY burst while master 1 asserts valid with addr=0x1000_0000. Required: addr never shows 0x1000_0000 until master 0 completes; m_ready[1]=0 the whole time.
- Async reset: assert reset mid-burst between clock edges. Required: valid=0 and m_ready=0 immediately, without waiting for a clock edge; after release, a new request from master 1 is arbitrated with rr_ptr=0, and master 1 is granted only if master 0 is not requesting.
- last without ready: last=1, ready=0 for 3 cycles, then ready=1. Required: completion and the IDLE transition happen only on the ready cycle.
